// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and one-hot helpers for the arbiters
package arb_pkg;

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    localparam int MAXN = 16;

    function automatic logic [3:0] onehot2bin(input logic [MAXN-1:0] v);
        logic [3:0] b = '0;
        for (int i = 0; i < MAXN; i++)
            if (v[4'(i)]) b |= 4'(i);
        return b;
    endfunction

    function automatic logic [MAXN-1:0] rotl1(input logic [MAXN-1:0] v, input int n);
        logic [MAXN-1:0] r = '0;
        for (int i = 0; i < MAXN; i++)
            if (i < n) r[4'(i)] = v[4'((i + n - 1) % n)];
        return r;
    endfunction

endpackage

// File: rtl/ptr_regn.sv
// ptr_regn: one-hot priority pointer register, clears to bit0, loads on en
module ptr_regn #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // pointer only moves when a grant ends
    always_ff @(posedge clk or negedge clr)
        if (!clr)   q <= N'(1);
        else if (en) q <= d;

endmodule

// File: rtl/regn.sv
// regn: plain W-bit register with asynchronous active-low clear to RV
module regn #(
    parameter int           W  = 1,
    parameter logic [W-1:0] RV = '0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // load every cycle, clear immediately on clr low
    always_ff @(posedge clk or negedge clr)
        if (!clr) q <= RV;
        else      q <= d;

endmodule

// File: rtl/rr_pick.sv
// rr_pick: first set bit of req searching from one-hot ptr upward, wrapping
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] win
);

    logic [2*N-1:0] dbl, first;

    // upper half is the wrapped copy; lower half keeps only bits at or above ptr
    always_comb begin
        dbl   = {req, req & ~(ptr - N'(1))};
        first = dbl & ~(dbl - (2*N)'(1));
        win   = first[N-1:0] | first[2*N-1:N];
    end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: round-robin one-hot arbiter with release, drop and hold-limit revoke
module rr_onehot_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8,
    parameter int CW       = 4,
    localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  rel,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          busy,
    output logic          expired
);

    state_t        state, state_n;
    logic          state_q;
    logic [N-1:0]  gnt_n, ptr, ptr_n, cand, pick_ptr, win;
    logic [CW-1:0] cnt, cnt_n;
    logic          expired_n, rel_own, drop, tmo, done;

    assign state = state_t'(state_q);

    regn #(.W(1))  u_state   (.clk(clk), .clr(clr), .d(1'(state_n)), .q(state_q));
    regn #(.W(N))  u_gnt     (.clk(clk), .clr(clr), .d(gnt_n),       .q(gnt));
    regn #(.W(CW)) u_cnt     (.clk(clk), .clr(clr), .d(cnt_n),       .q(cnt));
    regn #(.W(1))  u_expired (.clk(clk), .clr(clr), .d(expired_n),   .q(expired));

    ptr_regn #(.N(N)) u_ptr (.clk(clk), .clr(clr), .en(done), .d(ptr_n), .q(ptr));

    rr_pick #(.N(N)) u_pick (.req(cand), .ptr(pick_ptr), .win(win));

    // end-of-grant detection; the owner is excluded from the re-arbitration it triggers
    always_comb begin
        rel_own  = |(rel & gnt);
        drop     = ~|(req & gnt);
        tmo      = (HOLD_MAX != 0) && (cnt == CW'(HOLD_MAX - 1));
        done     = (state == OWN) && (rel_own || drop || tmo);
        ptr_n    = N'(rotl1(MAXN'(gnt), N));
        cand     = (state == OWN) ? (req & ~gnt) : req;
        pick_ptr = done ? ptr_n : ptr;
    end

    // next grant, state and hold counter; a release wins over a coincident timeout
    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        cnt_n     = (cnt == '1) ? cnt : cnt + 1'b1;
        expired_n = 1'b0;
        if (state == IDLE) begin
            gnt_n   = win;
            cnt_n   = '0;
            state_n = |req ? OWN : IDLE;
        end else if (done) begin
            gnt_n     = win;
            cnt_n     = '0;
            state_n   = |cand ? OWN : IDLE;
            expired_n = tmo && !rel_own;
        end
    end

    assign gnt_idx = IW'(onehot2bin(MAXN'(gnt)));
    assign busy    = |gnt;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb_rr_onehot_arbiter: directed checks of grant order, hold limit, release and reset
module tb_rr_onehot_arbiter;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] rel = '0;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy, expired;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    rr_onehot_arbiter #(.N(4), .HOLD_MAX(8), .CW(4)) dut (
        .clk(clk), .clr(clr), .req(req), .rel(rel),
        .gnt(gnt), .gnt_idx(gnt_idx), .busy(busy), .expired(expired)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        clr = 1'b0;
        req = '0;
        rel = '0;
        tick;
        tick;
        clr = 1'b1;
    endtask

    // structural invariants sampled mid-cycle
    always @(negedge clk) begin
        chk("onehot0", 32'($onehot0(gnt)), 1);
        chk("busy_eq", 32'(busy), 32'(|gnt));
    end

    initial begin
        #100000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 clr = 1'b0;
        #2;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_idx", 32'(gnt_idx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_exp", 32'(expired), 0);
        chk("rst_ptr", 32'(dut.ptr), 'h1);
        tick;
        clr = 1'b1;
        req = 4'b1010;
        chk("t1_pre", 32'(gnt), 0);
        tick;
        chk("t1_gnt", 32'(gnt), 'h2);
        chk("t1_idx", 32'(gnt_idx), 1);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_exp", 32'(expired), 0);
        rel = 4'b0010;
        tick;
        rel = '0;
        chk("t2_gnt", 32'(gnt), 'h8);
        chk("t2_idx", 32'(gnt_idx), 3);
        chk("t2_ptr", 32'(dut.ptr), 'h4);

        reset_dut;
        req = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            tick;
            chk("t3_hold", 32'(gnt), 'h1);
            chk("t3_hold_exp", 32'(expired), 0);
        end
        tick;
        chk("t3_gap_gnt", 32'(gnt), 0);
        chk("t3_gap_exp", 32'(expired), 1);
        tick;
        chk("t3_regnt", 32'(gnt), 'h1);
        chk("t3_regnt_exp", 32'(expired), 0);

        reset_dut;
        req = 4'b1111;
        tick;
        chk("t4_first", 32'(gnt), 'h1);
        begin
            logic [3:0] seq [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
            logic [3:0] own = 4'b0001;
            for (int i = 0; i < 6; i++) begin
                rel = own;
                tick;
                rel = '0;
                chk("t4_order", 32'(gnt), 32'(seq[i]));
                own = seq[i];
            end
        end
        #2 clr = 1'b0;
        #1;
        chk("t5_gnt", 32'(gnt), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_idx", 32'(gnt_idx), 0);
        #1 clr = 1'b1;
        req = 4'b1111;
        tick;
        chk("t5_regnt", 32'(gnt), 'h1);

        reset_dut;
        req = 4'b0011;
        tick;
        chk("t6_first", 32'(gnt), 'h1);
        for (int i = 0; i < 7; i++) begin
            tick;
            chk("t6_hold", 32'(gnt), 'h1);
        end
        chk("t6_cnt", 32'(dut.cnt), 7);
        rel = 4'b0001;
        tick;
        rel = '0;
        chk("t6_gnt", 32'(gnt), 'h2);
        chk("t6_idx", 32'(gnt_idx), 1);
        chk("t6_exp", 32'(expired), 0);
        req = 4'b0001;
        tick;
        chk("t6_drop_gnt", 32'(gnt), 'h1);
        chk("t6_drop_idx", 32'(gnt_idx), 0);
        chk("t6_drop_exp", 32'(expired), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
